// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer
// Initiator side of the FPU operation interface. Commands from the system bus
// are buffered in a small FIFO. Each command is issued to the FPU core, which
// receives registered operands, op select, round mode and start. The result
// and flags are then collected into a tagged response. Only one operation is
// in flight at a time, so responses come back in command order.
//
// Ports
//   clk, reset                  clock (posedge), asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op,
//   cmd_rm, cmd_tag             command payload
//   fpu_a, fpu_b, fpu_sel,
//   fpu_rm, fpu_start           registered drive to the FPU core
//   fpu_y, fpu_error,
//   fpu_overflow                FPU core result and flags
//   rsp_valid/rsp_ready         response handshake
//   rsp_y, rsp_error,
//   rsp_overflow, rsp_tag       captured response payload
//   busy                        high unless idle with an empty FIFO
//   fifo_count                  number of buffered commands
module fpu_cmd_issuer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int FPU_LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_a,
  input  logic [31:0]                cmd_b,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_rm,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [31:0]                fpu_a,
  output logic [31:0]                fpu_b,
  output logic [1:0]                 fpu_sel,
  output logic [1:0]                 fpu_rm,
  output logic                       fpu_start,
  input  logic [31:0]                fpu_y,
  input  logic                       fpu_error,
  input  logic                       fpu_overflow,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_y,
  output logic                       rsp_error,
  output logic                       rsp_overflow,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int CW    = $clog2(FPU_LATENCY + 1);
  localparam logic [CW-1:0]    LAT_C  = CW'(FPU_LATENCY);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t state_q, state_d;

  logic [31:0]      a_mem   [DEPTH];
  logic [31:0]      b_mem   [DEPTH];
  logic [1:0]       op_mem  [DEPTH];
  logic [1:0]       rm_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop, full, empty;

  assign full       = (count == FULL_C);
  assign empty      = (count == '0);
  // Gated by reset so the bus sees no ready while the block is held in reset.
  assign cmd_ready  = reset && !full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == IDLE) && !empty;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_count = count;

  // FIFO storage: payload only, never needs clearing since count guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= cmd_a;
      b_mem[wr_ptr]   <= cmd_b;
      op_mem[wr_ptr]  <= cmd_op;
      rm_mem[wr_ptr]  <= cmd_rm;
      tag_mem[wr_ptr] <= cmd_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty)         state_d = RUN;
      RUN:     if (cnt == LAT_C)   state_d = RESP;
      RESP:    if (rsp_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Issue / capture registers. The whole output set clears on reset so an
  // aborted operation leaves no trace on either interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_a        <= '0;
      fpu_b        <= '0;
      fpu_sel      <= '0;
      fpu_rm       <= '0;
      fpu_start    <= 1'b0;
      cnt          <= '0;
      tag_q        <= '0;
      rsp_valid    <= 1'b0;
      rsp_y        <= '0;
      rsp_error    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_tag      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            fpu_a     <= a_mem[rd_ptr];
            fpu_b     <= b_mem[rd_ptr];
            fpu_sel   <= op_mem[rd_ptr];
            fpu_rm    <= rm_mem[rd_ptr];
            tag_q     <= tag_mem[rd_ptr];
            fpu_start <= 1'b1;
            cnt       <= CW'(1);
          end
        end
        RUN: begin
          // cnt counts edges with start high; sampling on the LAT-th one
          // keeps start asserted for exactly FPU_LATENCY cycles.
          if (cnt == LAT_C) begin
            rsp_y        <= fpu_y;
            rsp_error    <= fpu_error;
            rsp_overflow <= fpu_overflow;
            rsp_tag      <= tag_q;
            rsp_valid    <= 1'b1;
            fpu_start    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
